// File: rtl/s1196_seq_core_pkg.sv
// s1196 benchmark core: shared widths, state layout and pin order.
// Imported by the model, the pin interface and the state register.
package s1196_seq_core_pkg;

    localparam int STATE_W = 18;
    localparam int IN_W    = 14;
    localparam int OUT_W   = 14;

    localparam int A_W = 8;
    localparam int C_W = 6;
    localparam int M_W = 4;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [C_W-1:0] c;
        logic [M_W-1:0] m;
    } state_t;

    // Bit positions in the flattened output vector; shared with the netlist.
    localparam int O_G45  = 0;
    localparam int O_G530 = 1;
    localparam int O_G532 = 2;
    localparam int O_G535 = 3;
    localparam int O_G537 = 4;
    localparam int O_G539 = 5;
    localparam int O_G542 = 6;
    localparam int O_G546 = 7;
    localparam int O_G547 = 8;
    localparam int O_G548 = 9;
    localparam int O_G549 = 10;
    localparam int O_G550 = 11;
    localparam int O_G551 = 12;
    localparam int O_G552 = 13;

    localparam logic [C_W-1:0] C_TERM = '1;

endpackage

// File: rtl/s1196_seq_core_if.sv
// s1196 pin bundle: primary inputs, enable and primary outputs.
// master drives the inputs, slave is the core's view.
interface s1196_seq_core_if;
    import s1196_seq_core_pkg::*;

    logic en;
    logic G0, G1, G2, G3, G4, G5, G6;
    logic G7, G8, G9, G10, G11, G12, G13;

    logic G45;
    logic G530, G532, G535, G537;
    logic G539, G542, G546, G547;
    logic G548, G549, G550, G551;
    logic G552;

    modport master (
        output en,
        output G0, G1, G2, G3, G4, G5, G6,
        output G7, G8, G9, G10, G11, G12, G13,
        input  G45,
        input  G530, G532, G535, G537,
        input  G539, G542, G546, G547,
        input  G548, G549, G550, G551,
        input  G552
    );

    modport slave (
        input  en,
        input  G0, G1, G2, G3, G4, G5, G6,
        input  G7, G8, G9, G10, G11, G12, G13,
        output G45,
        output G530, G532, G535, G537,
        output G539, G542, G546, G547,
        output G548, G549, G550, G551,
        output G552
    );
endinterface

// File: rtl/s1196_seq_core_state_reg.sv
// s1196 state register: 18 flops, async active-low clear,
// synchronous load enable.
module s1196_state_reg
    import s1196_seq_core_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [STATE_W-1:0] d,
    output logic [STATE_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/s1196_seq_core.sv
// s1196 behavioural core: accumulator, counter, mode shift register.
// Next-state and output logic; flops live in s1196_state_reg.
module s1196_seq_core
    import s1196_seq_core_pkg::*;
(
    input  logic reset,
    input  logic en,
    input  logic clk,
    input  logic G0,
    input  logic G1,
    input  logic G10,
    input  logic G11,
    input  logic G12,
    input  logic G13,
    input  logic G2,
    input  logic G3,
    input  logic G4,
    output logic G45,
    input  logic G5,
    output logic G530,
    output logic G532,
    output logic G535,
    output logic G537,
    output logic G539,
    output logic G542,
    output logic G546,
    output logic G547,
    output logic G548,
    output logic G549,
    output logic G550,
    output logic G551,
    output logic G552,
    input  logic G6,
    input  logic G7,
    input  logic G8,
    input  logic G9
);

    state_t         cur;
    state_t         nxt;
    logic [A_W-1:0] dOp;

    assign dOp = {G8, G7, G6, G5, G4, G3, G2, G1};

    // Add wraps mod 256; the carry out is intentionally dropped.
    always_comb begin
        nxt   = cur;
        nxt.a = G9 ? (cur.a ^ dOp) : (cur.a + dOp);
        nxt.c = G0 ? (cur.c + 1'b1) : cur.c;
        nxt.m = {cur.m[M_W-2:0], G10 ^ G11};
    end

    s1196_state_reg uState (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (nxt),
        .q     (cur)
    );

    assign G45  = G12 & G13 & ~cur.m[M_W-1];
    assign G552 = (cur.c == C_TERM);

    assign {G547, G546, G542, G539,
            G537, G535, G532, G530} = cur.a;
    assign {G551, G550, G549, G548} = cur.c[3:0];

endmodule

// File: tb/tb_s1196_seq_core.sv
// Directed bench for s1196_seq_core with hand-computed expectations.
// Inputs change 1ns after the rising edge and are checked there.
module tb_s1196_seq_core;
    import s1196_seq_core_pkg::*;

    logic clk;
    logic reset;
    int   nVec;
    int   nErr;

    s1196_seq_core_if pins ();

    s1196_seq_core dut (
        .reset (reset),
        .en    (pins.en),
        .clk   (clk),
        .G0    (pins.G0),
        .G1    (pins.G1),
        .G10   (pins.G10),
        .G11   (pins.G11),
        .G12   (pins.G12),
        .G13   (pins.G13),
        .G2    (pins.G2),
        .G3    (pins.G3),
        .G4    (pins.G4),
        .G45   (pins.G45),
        .G5    (pins.G5),
        .G530  (pins.G530),
        .G532  (pins.G532),
        .G535  (pins.G535),
        .G537  (pins.G537),
        .G539  (pins.G539),
        .G542  (pins.G542),
        .G546  (pins.G546),
        .G547  (pins.G547),
        .G548  (pins.G548),
        .G549  (pins.G549),
        .G550  (pins.G550),
        .G551  (pins.G551),
        .G552  (pins.G552),
        .G6    (pins.G6),
        .G7    (pins.G7),
        .G8    (pins.G8),
        .G9    (pins.G9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] accOut();
        return {pins.G547, pins.G546, pins.G542, pins.G539,
                pins.G537, pins.G535, pins.G532, pins.G530};
    endfunction

    function automatic logic [3:0] cntOut();
        return {pins.G551, pins.G550, pins.G549, pins.G548};
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic setD(input logic [7:0] d);
        {pins.G8, pins.G7, pins.G6, pins.G5,
         pins.G4, pins.G3, pins.G2, pins.G1} = d;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        nVec = 0;
        nErr = 0;
        reset = 1'b0;
        pins.en = 1'b1;
        setD(8'h00);
        pins.G0 = 0; pins.G9 = 0;
        pins.G10 = 0; pins.G11 = 0;
        pins.G12 = 1; pins.G13 = 1;

        #3;
        check("rst_acc", accOut(), 8'h00);
        check("rst_cnt", cntOut(), 4'h0);
        check("rst_tc", pins.G552, 1'b0);
        check("rst_g45", pins.G45, 1'b1);

        pins.G12 = 0; pins.G13 = 0;
        tick(1);
        reset = 1'b1;
        tick(5);
        check("idle_acc", accOut(), 8'h00);
        check("idle_cnt", cntOut(), 4'h0);
        check("idle_g45", pins.G45, 1'b0);

        setD(8'h05);
        tick(3);
        check("add_3x5", accOut(), 8'h0F);
        check("add_bits", {pins.G537, pins.G530}, 2'b11);
        check("add_hi", {pins.G547, pins.G539}, 2'b00);
        setD(8'hF1);
        tick(1);
        check("add_wrap", accOut(), 8'h00);

        setD(8'h0F);
        tick(1);
        check("add_0f", accOut(), 8'h0F);
        pins.G9 = 1;
        setD(8'hFF);
        tick(1);
        check("xor_1", accOut(), 8'hF0);
        tick(1);
        check("xor_2", accOut(), 8'h0F);

        pins.G9 = 0;
        setD(8'h00);
        pulseReset();
        check("rst_clr", accOut(), 8'h00);
        pins.G0 = 1;
        tick(62);
        check("cnt_62", cntOut(), 4'hE);
        check("cnt_62tc", pins.G552, 1'b0);
        tick(1);
        check("cnt_63", cntOut(), 4'hF);
        check("cnt_63tc", pins.G552, 1'b1);
        tick(1);
        check("cnt_wrap", cntOut(), 4'h0);
        check("cnt_wraptc", pins.G552, 1'b0);
        tick(5);
        check("cnt_5", cntOut(), 4'h5);
        pins.G0 = 0;
        tick(3);
        check("cnt_hold", cntOut(), 4'h5);

        pins.G12 = 1; pins.G13 = 1;
        pins.G10 = 1; pins.G11 = 0;
        #1;
        check("m_g45_0", pins.G45, 1'b1);
        tick(3);
        check("m_g45_3", pins.G45, 1'b1);
        tick(1);
        check("m_g45_4", pins.G45, 1'b0);
        pins.G11 = 1;
        tick(3);
        check("m_g45_7", pins.G45, 1'b0);
        tick(1);
        check("m_g45_8", pins.G45, 1'b1);

        pins.en = 0;
        pins.G0 = 1;
        pins.G11 = 0;
        setD(8'h01);
        tick(10);
        check("en_acc", accOut(), 8'h00);
        check("en_cnt", cntOut(), 4'h5);
        check("en_g45", pins.G45, 1'b1);
        pins.G13 = 0;
        #1;
        check("en_g45c", pins.G45, 1'b0);
        pins.G13 = 1;
        pins.en = 1;
        tick(1);
        check("en_acc1", accOut(), 8'h01);
        check("en_cnt1", cntOut(), 4'h6);

        #2;
        reset = 1'b0;
        #1;
        check("mid_acc", accOut(), 8'h00);
        check("mid_cnt", cntOut(), 4'h0);
        check("mid_g45", pins.G45, 1'b1);
        tick(1);
        check("mid_hold", cntOut(), 4'h0);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==",
                 nVec, nErr);
        $finish;
    end

endmodule
